// File: rtl/rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// rr_onehot_arbiter
//   Round-robin arbiter producing a registered one-hot grant that drives the
//   select input of a one-hot 4:1 mux directly. A holder may keep the grant
//   for at most MAX_HOLD consecutive cycles. On release the next grant is
//   issued on the same edge, so there is no idle bubble between bursts.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   req_i        request vector, bit k high = source k wants the mux
//   gnt_o        registered one-hot grant, all-zero when idle
//   gnt_valid_o  high when gnt_o is non-zero
//   gnt_idx_o    binary index of the granted bit, 0 when idle
// ---------------------------------------------------------------------------
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQ-1:0]                        req_i,
  output logic [NUM_REQ-1:0]                        gnt_o,
  output logic                                      gnt_valid_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_reg, state_next;
  // ptr doubles as the holder index while in GRANT; in IDLE it remembers
  // the last holder so the next search starts just after it.
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic               any_req;
  logic               keep_holder;
  logic [IDX_W-1:0]   pick_next;

  // First set request bit scanning last+1, last+2, ... with wrap-around.
  // The scan ends on 'last' itself, so the previous holder only wins again
  // when it is the sole requester.
  function automatic logic [IDX_W-1:0] pick_after(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && r[cand_idx]) begin
        sel   = cand_idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDX_W'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    any_req       = |req_i;
    pick_next     = pick_after(req_i, ptr_reg);
    keep_holder   = req_i[ptr_reg] && (hold_cnt_reg < CNT_W'(MAX_HOLD));
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = GRANT;
          ptr_next      = pick_next;
          hold_cnt_next = CNT_W'(1);
        end
      end
      GRANT: begin
        if (keep_holder) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end else if (any_req) begin
          // Release with re-grant on the same edge (fresh burst).
          ptr_next      = pick_next;
          hold_cnt_next = CNT_W'(1);
        end else begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Output logic: decoded purely from registers, so there is no
  // combinational path from req_i to the grant outputs.
  always_comb begin
    gnt_valid_o = (state_reg == GRANT);
    gnt_idx_o   = gnt_valid_o ? ptr_reg : '0;
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt_o[gi] = (state_reg == GRANT) && (ptr_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that produces the one-hot select word consumed by the team's one-hot 4:1 select mux (sel_i side of day13).
- Takes per-source request lines and issues a registered one-hot grant.
- Supports a bounded burst hold: the holder keeps the grant for a limited number of cycles.
- Sits upstream of the mux; gnt_o drives the mux sel_i directly.

Parameters:
- NUM_REQ, 4, number of requesters; equals the gnt_o width and the mux select width.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  request vector; bit k high = source k wants the mux.
- gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_valid_o  output  1  high when gnt_o is non-zero.
- gnt_idx_o  output  $clog2(NUM_REQ)  binary index of the granted bit; 0 when idle.

Behaviour:
- Reset: one clock, synchronous, active-high; reset sampled high at a rising edge clears all state at that edge.
  - Reset values: gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, hold_cnt=0, ptr=NUM_REQ-1 (so the first search starts at index 0), state=IDLE.
- Reset mid-grant: grant drops on the same edge; no completion of the burst.
- Invariant: gnt_o is always zero or exactly one-hot; gnt_idx_o and gnt_valid_o are consistent with it every cycle.
- Latency: req_i sampled at edge N, resulting grant visible after edge N (one registered stage); no combinational path from req_i to gnt_o.
- Arbitration function pick(from): the first set bit of req_i scanning indices from, from+1, ... modulo NUM_REQ; wraps past NUM_REQ-1 to 0.
- State IDLE (gnt_o=0):
  - Any req_i bit set -> grant pick(ptr+1), hold_cnt=1, ptr=granted index, go GRANT.
  - Otherwise stay IDLE.
- State GRANT (holder h):
  - Continue: req_i[h]=1 and hold_cnt<MAX_HOLD -> keep gnt_o, hold_cnt+=1.
  - Release: req_i[h]=0 or hold_cnt==MAX_HOLD.
    - If any req_i bit is set -> re-grant pick(h+1) on the same edge (no idle bubble), hold_cnt=1, ptr=new index.
    - Because the scan wraps, h wins again only when it is the sole requester; after the cap it receives a fresh burst.
    - If no request -> gnt_o=0, go IDLE; ptr keeps h.
- Dropping a non-holder request has no effect.
- Raising requests while another source holds the grant does not preempt; those sources wait for release.
- Counter: hold_cnt width $clog2(MAX_HOLD+1); it never exceeds MAX_HOLD.
- MAX_HOLD=1: the grant rotates every cycle while multiple requesters are active.
- Fairness bound: a continuously asserted request is granted within (NUM_REQ-1)*MAX_HOLD+1 cycles.

Test Plan:
- Reset: reset=1 for 2 cycles with req_i=4'b1111 -> gnt_o=0, gnt_valid_o=0, gnt_idx_o=0 throughout.
  - Release reset -> gnt_o=4'b0001 after the first edge.
- Single requester: req_i=4'b0100 held for 6 cycles -> gnt_o=4'b0100, gnt_idx_o=2.
  - Sole requester is re-granted after the cap, so the grant stays continuous.
  - req_i=0 -> gnt_o=0 the next cycle.
- Rotation with cap: req_i=4'b1111 held, MAX_HOLD=4 -> grants 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
  - No zero cycles between bursts.
- Early release: req_i=4'b0011; after 2 cycles of 0001, drop bit 0 (req_i=4'b0010) -> gnt_o=4'b0010 on the next edge.
  - hold_cnt restarts at 1.
- Wrap-around: ptr=3 (last grant 1000), req_i=4'b1001 -> next grant 0001.
  - Then, at 0001 release with req_i=4'b1000 -> grant 1000.
- Mux integration: gnt_o drives day13 sel_i with a_i=4'b1010 and req_i=4'b1111 rotating.
  - y outputs follow 0,1,0,1 per burst; a one-hot check passes on every cycle.
